// File: rtl/mcpu_ifetch.sv
// MCPU instruction fetch: drives both ROM read ports, assembles opcode plus optional
// little-endian immediate, and hands each instruction to execute over valid/ready.
module mcpu_ifetch #(
  parameter int unsigned                   IROM_ADDR_BITS = 14,
  parameter int unsigned                   IMM_BYTES      = 4,
  parameter logic [IROM_ADDR_BITS-1:0]     RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [IROM_ADDR_BITS-1:0] irom_addr0,
  input  logic [7:0]                irom_out0,
  output logic [IROM_ADDR_BITS-1:0] irom_addr1,
  input  logic [7:0]                irom_out1,
  input  logic                      pc_load,
  input  logic [IROM_ADDR_BITS-1:0] pc_load_addr,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [7:0]                instr_opcode,
  output logic                      instr_has_imm,
  output logic [31:0]               instr_imm,
  output logic [IROM_ADDR_BITS-1:0] instr_pc,
  output logic [IROM_ADDR_BITS-1:0] fetch_pc
);

  localparam int unsigned AW       = IROM_ADDR_BITS;
  localparam logic [2:0]  ImmBytes = 3'(IMM_BYTES);

  typedef enum logic [1:0] {StOp, StImm, StOut} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      opcode_q, opcode_d;
  logic            has_imm_q, has_imm_d;
  logic [31:0]     imm_q, imm_d;
  logic [AW-1:0]   instr_pc_q, instr_pc_d;

  logic [AW-1:0]   pc_p1, pc_p2;
  logic            two_left;

  assign pc_p1    = pc_q + AW'(1);
  assign pc_p2    = pc_q + AW'(2);
  assign two_left = (ImmBytes - cnt_q) >= 3'd2;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    has_imm_d  = has_imm_q;
    imm_d      = imm_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      StOp: begin
        opcode_d   = irom_out0;
        has_imm_d  = irom_out0[7];
        instr_pc_d = pc_q;
        imm_d      = '0;
        if (!irom_out0[7]) begin
          pc_d    = pc_p1;
          cnt_d   = 3'd0;
          state_d = StOut;
        end else begin
          imm_d[7:0] = irom_out1;
          pc_d       = pc_p2;
          cnt_d      = 3'd1;
          state_d    = (ImmBytes == 3'd1) ? StOut : StImm;
        end
      end
      StImm: begin
        // Port 0 fills byte[cnt]; port 1 fills byte[cnt+1] when the immediate has room.
        for (int unsigned b = 0; b < 4; b++) begin
          if (cnt_q == 3'(b)) imm_d[8*b +: 8] = irom_out0;
          if (two_left && (cnt_q + 3'd1 == 3'(b))) imm_d[8*b +: 8] = irom_out1;
        end
        if (two_left) begin
          pc_d  = pc_p2;
          cnt_d = cnt_q + 3'd2;
        end else begin
          pc_d  = pc_p1;
          cnt_d = cnt_q + 3'd1;
        end
        if (cnt_d == ImmBytes) state_d = StOut;
      end
      StOut: begin
        if (instr_ready) begin
          state_d = StOp;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = StOp;
    endcase

    // Redirect discards any partial instruction but leaves the output registers alone.
    if (pc_load) begin
      pc_d       = pc_load_addr;
      state_d    = StOp;
      cnt_d      = 3'd0;
      opcode_d   = opcode_q;
      has_imm_d  = has_imm_q;
      imm_d      = imm_q;
      instr_pc_d = instr_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StOp;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      opcode_q   <= 8'h00;
      has_imm_q  <= 1'b0;
      imm_q      <= 32'h0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      has_imm_q  <= has_imm_d;
      imm_q      <= imm_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign irom_addr0    = pc_q;
  assign irom_addr1    = pc_p1;
  assign instr_valid   = (state_q == StOut);
  assign instr_opcode  = opcode_q;
  assign instr_has_imm = has_imm_q;
  assign instr_imm     = imm_q;
  assign instr_pc      = instr_pc_q;
  assign fetch_pc      = pc_q;

endmodule
